// File: rtl/conv_processor_tap_line.sv
// Tapped shift line for the convolution processor. Every stage is exposed in parallel, with
// fill tracking and reporting of evicted samples.
module conv_processor_tap_line #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clear,
  input  logic                          shift,
  input  logic                          rotate,
  input  logic [DATA_WIDTH-1:0]         data_in,
  output logic [DEPTH*DATA_WIDTH-1:0]   taps,
  output logic [$clog2(DEPTH+1)-1:0]    count,
  output logic                          full,
  output logic                          evict_valid,
  output logic [DATA_WIDTH-1:0]         evict_data
);

  localparam int unsigned CntWidth = $clog2(DEPTH + 1);

  logic [DATA_WIDTH-1:0] tap_q [DEPTH];
  logic [DATA_WIDTH-1:0] tap_d [DEPTH];
  logic [CntWidth-1:0]   count_q, count_d;
  logic                  evict_valid_q, evict_valid_d;
  logic [DATA_WIDTH-1:0] evict_data_q, evict_data_d;

  assign full = (count_q == CntWidth'(DEPTH));

  always_comb begin
    tap_d         = tap_q;
    count_d       = count_q;
    evict_valid_d = 1'b0;
    evict_data_d  = evict_data_q;
    if (clear) begin
      for (int k = 0; k < DEPTH; k++) tap_d[k] = '0;
      count_d      = '0;
      evict_data_d = '0;
    end else if (shift) begin
      for (int k = 1; k < DEPTH; k++) tap_d[k] = tap_q[k-1];
      if (rotate) begin
        // Ring mode: the oldest stage wraps to the front, nothing leaves.
        tap_d[0] = tap_q[DEPTH-1];
      end else begin
        tap_d[0] = data_in;
        if (!full) count_d = count_q + CntWidth'(1);
        if (full) begin
          evict_valid_d = 1'b1;
          evict_data_d  = tap_q[DEPTH-1];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) tap_q[k] <= '0;
      count_q       <= '0;
      evict_valid_q <= 1'b0;
      evict_data_q  <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) tap_q[k] <= tap_d[k];
      count_q       <= count_d;
      evict_valid_q <= evict_valid_d;
      evict_data_q  <= evict_data_d;
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : gen_taps
    assign taps[g*DATA_WIDTH +: DATA_WIDTH] = tap_q[g];
  end

  assign count       = count_q;
  assign evict_valid = evict_valid_q;
  assign evict_data  = evict_data_q;

endmodule

// File: tb/tb_conv_processor_tap_line.sv
// Directed bench for conv_processor_tap_line: a default 4x8 instance and a 2x16 instance.
module tb_conv_processor_tap_line;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: DEPTH=4, DATA_WIDTH=8
  logic        rst, clear, shift, rotate;
  logic [7:0]  data_in;
  logic [31:0] taps;
  logic [2:0]  count;
  logic        full, evict_valid;
  logic [7:0]  evict_data;

  // Instance B: DEPTH=2, DATA_WIDTH=16
  logic        b_rst, b_clear, b_shift, b_rotate;
  logic [15:0] b_data_in;
  logic [31:0] b_taps;
  logic [1:0]  b_count;
  logic        b_full, b_evict_valid;
  logic [15:0] b_evict_data;

  int n_cmp = 0;
  int n_fail = 0;

  conv_processor_tap_line #(.DATA_WIDTH(8), .DEPTH(4)) u_dut_a (
    .clk(clk), .rst(rst), .clear(clear), .shift(shift), .rotate(rotate), .data_in(data_in),
    .taps(taps), .count(count), .full(full), .evict_valid(evict_valid),
    .evict_data(evict_data)
  );

  conv_processor_tap_line #(.DATA_WIDTH(16), .DEPTH(2)) u_dut_b (
    .clk(clk), .rst(b_rst), .clear(b_clear), .shift(b_shift), .rotate(b_rotate),
    .data_in(b_data_in), .taps(b_taps), .count(b_count), .full(b_full),
    .evict_valid(b_evict_valid), .evict_data(b_evict_data)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_a(input string tag, input logic [31:0] t, input logic [2:0] c,
                       input logic f, input logic ev, input logic [7:0] ed);
    chk({tag, ".taps"}, 64'(taps), 64'(t));
    chk({tag, ".count"}, 64'(count), 64'(c));
    chk({tag, ".full"}, 64'(full), 64'(f));
    chk({tag, ".evict_valid"}, 64'(evict_valid), 64'(ev));
    chk({tag, ".evict_data"}, 64'(evict_data), 64'(ed));
  endtask

  task automatic chk_b(input string tag, input logic [31:0] t, input logic [1:0] c,
                       input logic f, input logic ev, input logic [15:0] ed);
    chk({tag, ".taps"}, 64'(b_taps), 64'(t));
    chk({tag, ".count"}, 64'(b_count), 64'(c));
    chk({tag, ".full"}, 64'(b_full), 64'(f));
    chk({tag, ".evict_valid"}, 64'(b_evict_valid), 64'(ev));
    chk({tag, ".evict_data"}, 64'(b_evict_data), 64'(ed));
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; shift = 1'b0; rotate = 1'b0; data_in = 8'h00;
    b_rst = 1'b1; b_clear = 1'b0; b_shift = 1'b0; b_rotate = 1'b0; b_data_in = 16'h0;
    step();
    step();
    rst = 1'b0; b_rst = 1'b0;
    chk_a("reset", 32'h0, 3'd0, 1'b0, 1'b0, 8'h00);
    chk_b("b_reset", 32'h0, 2'd0, 1'b0, 1'b0, 16'h0);

    // Fill
    shift = 1'b1; data_in = 8'h11; step();
    chk_a("fill1", 32'h00000011, 3'd1, 1'b0, 1'b0, 8'h00);
    data_in = 8'h22; step();
    chk_a("fill2", 32'h00001122, 3'd2, 1'b0, 1'b0, 8'h00);
    data_in = 8'h33; step();
    chk_a("fill3", 32'h00112233, 3'd3, 1'b0, 1'b0, 8'h00);
    data_in = 8'h44; step();
    chk_a("fill4", 32'h11223344, 3'd4, 1'b1, 1'b0, 8'h00);

    // Slide with eviction, then idle
    data_in = 8'h55; step();
    chk_a("slide", 32'h22334455, 3'd4, 1'b1, 1'b1, 8'h11);
    shift = 1'b0; data_in = 8'h99; step();
    chk_a("idle", 32'h22334455, 3'd4, 1'b1, 1'b0, 8'h11);

    // Clear, then refill for the rotate test
    clear = 1'b1; step();
    chk_a("clear", 32'h0, 3'd0, 1'b0, 1'b0, 8'h00);
    clear = 1'b0; shift = 1'b1;
    data_in = 8'h11; step();
    data_in = 8'h22; step();
    data_in = 8'h33; step();
    data_in = 8'h44; step();
    chk_a("refill", 32'h11223344, 3'd4, 1'b1, 1'b0, 8'h00);

    // Rotate once, then three more to restore
    rotate = 1'b1; data_in = 8'hEE; step();
    chk_a("rot1", 32'h22334411, 3'd4, 1'b1, 1'b0, 8'h00);
    step();
    step();
    step();
    chk_a("rot4", 32'h11223344, 3'd4, 1'b1, 1'b0, 8'h00);

    // Evicting slide sets evict_data, then clear+shift: clear must win
    rotate = 1'b0; data_in = 8'h55; step();
    chk_a("slide2", 32'h22334455, 3'd4, 1'b1, 1'b1, 8'h11);
    clear = 1'b1; data_in = 8'hFF; step();
    chk_a("clear_shift", 32'h0, 3'd0, 1'b0, 1'b0, 8'h00);

    // Refill, evict, then rst with shift: rst must win
    clear = 1'b0;
    data_in = 8'h11; step();
    data_in = 8'h22; step();
    data_in = 8'h33; step();
    data_in = 8'h44; step();
    data_in = 8'h55; step();
    chk_a("slide3", 32'h22334455, 3'd4, 1'b1, 1'b1, 8'h11);
    rst = 1'b1; data_in = 8'hFF; step();
    chk_a("rst_shift", 32'h0, 3'd0, 1'b0, 1'b0, 8'h00);
    rst = 1'b0;

    // Partial rotate
    data_in = 8'hA1; step();
    data_in = 8'hB2; step();
    chk_a("part_fill", 32'h0000A1B2, 3'd2, 1'b0, 1'b0, 8'h00);
    rotate = 1'b1; data_in = 8'hCC; step();
    chk_a("part_rot", 32'h00A1B200, 3'd2, 1'b0, 1'b0, 8'h00);
    shift = 1'b0; step();
    chk_a("rot_no_shift", 32'h00A1B200, 3'd2, 1'b0, 1'b0, 8'h00);
    rotate = 1'b0;

    // DEPTH=2 saturation and eviction sequence
    b_shift = 1'b1;
    b_data_in = 16'h0001; step();
    chk_b("b_s1", 32'h0000_0001, 2'd1, 1'b0, 1'b0, 16'h0000);
    b_data_in = 16'h0002; step();
    chk_b("b_s2", 32'h0001_0002, 2'd2, 1'b1, 1'b0, 16'h0000);
    b_data_in = 16'h0003; step();
    chk_b("b_s3", 32'h0002_0003, 2'd2, 1'b1, 1'b1, 16'h0001);
    b_data_in = 16'h0004; step();
    chk_b("b_s4", 32'h0003_0004, 2'd2, 1'b1, 1'b1, 16'h0002);
    b_data_in = 16'h0005; step();
    chk_b("b_s5", 32'h0004_0005, 2'd2, 1'b1, 1'b1, 16'h0003);
    b_shift = 1'b0; step();
    chk_b("b_idle", 32'h0004_0005, 2'd2, 1'b1, 1'b0, 16'h0003);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
